// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: control/status bundle between the multicycle control FSM and the datapath/ALU
interface mips_multicycle_ctrl_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       Mem_Ready;
  logic       PC_Write;
  logic       IorD;
  logic       Mem_Read;
  logic       Mem_Write;
  logic       IR_Write;
  logic       Mem_To_Reg;
  logic       Reg_Dst;
  logic       Reg_Write;
  logic       ALU_Src_A;
  logic [1:0] ALU_Src_B;
  logic [1:0] PC_Source;
  logic [3:0] ALUctrl;
  logic       Illegal;
  logic [3:0] State;
  modport master (
    input  Opcode, Funct, Zero, Mem_Ready,
    output PC_Write, IorD, Mem_Read, Mem_Write, IR_Write, Mem_To_Reg, Reg_Dst, Reg_Write,
           ALU_Src_A, ALU_Src_B, PC_Source, ALUctrl, Illegal, State
  );
  modport slave (
    output Opcode, Funct, Zero, Mem_Ready,
    input  PC_Write, IorD, Mem_Read, Mem_Write, IR_Write, Mem_To_Reg, Reg_Dst, Reg_Write,
           ALU_Src_A, ALU_Src_B, PC_Source, ALUctrl, Illegal, State
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS main control FSM driving datapath strobes and ALU operation
// Optional NOR R-type support is enabled by defining ALU_NOR_EN.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input logic clk,
  input logic reset,
  mips_multicycle_ctrl_if.master bus
);
  localparam logic [STATE_W-1:0] FETCH  = 4'd0;
  localparam logic [STATE_W-1:0] DECODE = 4'd1;
  localparam logic [STATE_W-1:0] MEMADR = 4'd2;
  localparam logic [STATE_W-1:0] MEMRD  = 4'd3;
  localparam logic [STATE_W-1:0] MEMWB  = 4'd4;
  localparam logic [STATE_W-1:0] MEMWR  = 4'd5;
  localparam logic [STATE_W-1:0] EXEC   = 4'd6;
  localparam logic [STATE_W-1:0] ALUWB  = 4'd7;
  localparam logic [STATE_W-1:0] BRANCH = 4'd8;
  localparam logic [STATE_W-1:0] ADDIEX = 4'd9;
  localparam logic [STATE_W-1:0] ADDIWB = 4'd10;
  localparam logic [STATE_W-1:0] JUMP   = 4'd11;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  logic [STATE_W-1:0] state, state_nx;
  logic [3:0] fn_code;
  logic       fn_ok;
  logic       op_ok;
  always_ff @(posedge clk)
    if (reset) state <= FETCH;
    else state <= state_nx;
  // Funct stays stable through ALUWB, so the EXEC code can be re-derived there
  always_comb begin
    fn_ok = 1'b1;
    fn_code = OP_ADD;
    case (bus.Funct)
      6'b100000: fn_code = OP_ADD;
      6'b100010: fn_code = OP_SUB;
      6'b100100: fn_code = OP_AND;
      6'b100101: fn_code = OP_OR;
      6'b101010: fn_code = OP_SLT;
`ifdef ALU_NOR_EN
      6'b100111: fn_code = OP_NOR;
`else
`endif
      default:   fn_ok = 1'b0;
    endcase
  end
  assign op_ok = bus.Opcode inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:  state_nx = bus.Mem_Ready ? DECODE : FETCH;
      DECODE: state_nx = bus.Opcode == 6'b000000 ? EXEC :
                         bus.Opcode == 6'b100011 || bus.Opcode == 6'b101011 ? MEMADR :
                         bus.Opcode == 6'b000100 ? BRANCH :
                         bus.Opcode == 6'b001000 ? ADDIEX :
                         bus.Opcode == 6'b000010 ? JUMP : FETCH;
      MEMADR: state_nx = bus.Opcode[3] ? MEMWR : MEMRD;
      MEMRD:  state_nx = bus.Mem_Ready ? MEMWB : MEMRD;
      MEMWR:  state_nx = bus.Mem_Ready ? FETCH : MEMWR;
      EXEC:   state_nx = fn_ok ? ALUWB : FETCH;
      ADDIEX: state_nx = ADDIWB;
      default: state_nx = FETCH;
    endcase
  end
  // Reset overrides every strobe so an abandoned instruction never writes
  always_comb begin
    bus.PC_Write   = 1'b0;
    bus.IorD       = 1'b0;
    bus.Mem_Read   = 1'b0;
    bus.Mem_Write  = 1'b0;
    bus.IR_Write   = 1'b0;
    bus.Mem_To_Reg = 1'b0;
    bus.Reg_Dst    = 1'b0;
    bus.Reg_Write  = 1'b0;
    bus.ALU_Src_A  = 1'b0;
    bus.ALU_Src_B  = 2'b00;
    bus.PC_Source  = 2'b00;
    bus.ALUctrl    = OP_ADD;
    bus.Illegal    = 1'b0;
    if (!reset)
      case (state)
        FETCH: begin
          bus.Mem_Read  = 1'b1;
          bus.ALU_Src_B = 2'b01;
          bus.IR_Write  = bus.Mem_Ready;
          bus.PC_Write  = bus.Mem_Ready;
        end
        DECODE: begin
          bus.ALU_Src_B = 2'b11;
          bus.Illegal   = !op_ok;
        end
        MEMADR, ADDIEX: begin
          bus.ALU_Src_A = 1'b1;
          bus.ALU_Src_B = 2'b10;
        end
        MEMRD: begin
          bus.Mem_Read = 1'b1;
          bus.IorD     = 1'b1;
        end
        MEMWB: begin
          bus.Reg_Write  = 1'b1;
          bus.Mem_To_Reg = 1'b1;
        end
        MEMWR: begin
          bus.Mem_Write = 1'b1;
          bus.IorD      = 1'b1;
        end
        EXEC: begin
          bus.ALU_Src_A = 1'b1;
          bus.ALUctrl   = fn_code;
          bus.Illegal   = !fn_ok;
        end
        ALUWB: begin
          bus.Reg_Write = 1'b1;
          bus.Reg_Dst   = 1'b1;
          bus.ALUctrl   = fn_code;
        end
        BRANCH: begin
          bus.ALU_Src_A = 1'b1;
          bus.ALUctrl   = OP_SUB;
          bus.PC_Source = 2'b01;
          bus.PC_Write  = bus.Zero;
        end
        ADDIWB: bus.Reg_Write = 1'b1;
        JUMP: begin
          bus.PC_Source = 2'b10;
          bus.PC_Write  = 1'b1;
        end
        default: ;
      endcase
  end
  assign bus.State = state;
endmodule
